// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment capture path: segment patterns (active-low, seg[6:0] = g..a),
// digit geometry, anode position indices and the capture FSM state type.
package seg_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [1:0] POS_SECONDS      = 2'd0;
    localparam logic [1:0] POS_DECA_SECONDS = 2'd1;
    localparam logic [1:0] POS_MINUTES      = 2'd2;
    localparam logic [1:0] POS_DECA_MINUTES = 2'd3;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } cap_state_e;

    // Digit position selected by a legal active-low one-hot anode vector.
    function automatic logic [1:0] onehot_pos(input logic [3:0] an);
        case (an)
            4'b1101: return POS_DECA_SECONDS;
            4'b1011: return POS_MINUTES;
            4'b0111: return POS_DECA_MINUTES;
            default: return POS_SECONDS;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to BCD decoder, the inverse of the display encoder.
// Patterns outside the ten legal digits report valid_o=0.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0]       pat_i,
    output logic             valid_o,
    output logic [BCD_W-1:0] bcd_o
);

    always_comb begin
        valid_o = 1'b1;
        bcd_o   = 4'd0;
        case (pat_i)
            SEG_0:   bcd_o = 4'd0;
            SEG_1:   bcd_o = 4'd1;
            SEG_2:   bcd_o = 4'd2;
            SEG_3:   bcd_o = 4'd3;
            SEG_4:   bcd_o = 4'd4;
            SEG_5:   bcd_o = 4'd5;
            SEG_6:   bcd_o = 4'd6;
            SEG_7:   bcd_o = 4'd7;
            SEG_8:   bcd_o = 4'd8;
            SEG_9:   bcd_o = 4'd9;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Recovers a 4-digit BCD value from a multiplexed seg/an bus; publishes 2 cycles after the sample completing a
// qualifying frame, no backpressure. Define SEG_CAPTURE_DP_EN to capture decimal points as part of the frame.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int SETTLE_CYC    = 16,
    parameter int STABLE_FRAMES = 2,
    parameter int TIMEOUT_CYC   = 2000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  seg_in,
    input  logic [3:0]                  an_in,
    output logic [NUM_DIGITS*BCD_W-1:0] digit_out,
    output logic [NUM_DIGITS-1:0]       dp_out,
    output logic                        frame_valid,
    output logic                        locked,
    output logic                        decode_err,
    output logic                        an_err
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam int MW = $clog2(STABLE_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [MW-1:0] MATCH_MAX   = MW'(STABLE_FRAMES);
    localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYC);

    logic                  dp_raw;
`ifdef SEG_CAPTURE_DP_EN
    assign dp_raw = seg_in[7];
`else
    logic unused_dp;
    assign unused_dp = seg_in[7];
    assign dp_raw    = 1'b1;
`endif

    cap_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            an_r_q, an_p_q;
    logic [6:0]            seg_r_q;
    logic                  dp_r_q;
    logic [15:0]           shadow_q, cand_q, digit_q;
    logic [3:0]            shadow_dp_q, cand_dp_q, dp_q;
    logic [3:0]            seen_q;
    logic                  sampled_q, pub_q;
    logic [MW-1:0]         match_q, match_d;
    logic [TW-1:0]         to_q;
    logic                  fv_q, locked_q, dec_err_q, an_err_q;

    logic                  changed, an_one, an_idle, react;
    logic                  sample_en, an_err_d;
    logic                  dec_vld;
    logic [BCD_W-1:0]      dec_bcd;
    logic [1:0]            pos;
    logic                  complete, frame_same, timed_out, publish;

    seg7_decode u_dec (
        .pat_i   (seg_r_q),
        .valid_o (dec_vld),
        .bcd_o   (dec_bcd)
    );

    assign changed = (an_r_q != an_p_q);
    assign an_one  = (an_r_q == 4'b1110) || (an_r_q == 4'b1101) ||
                     (an_r_q == 4'b1011) || (an_r_q == 4'b0111);
    assign an_idle = (an_r_q == 4'b1111);
    assign pos     = onehot_pos(an_r_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sample_en = 1'b0;
        an_err_d  = 1'b0;
        react     = 1'b0;
        case (state_q)
            ST_IDLE:   react = 1'b1;
            ST_SETTLE: begin
                if (changed) begin
                    react = 1'b1;
                end else if (cnt_q >= SETTLE_LAST) begin
                    sample_en = 1'b1;
                    state_d   = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD:   react = changed;
            default:   state_d = ST_IDLE;
        endcase
        // A new anode value is judged the same way from every state.
        if (react) begin
            if (an_one) begin
                state_d = ST_SETTLE;
                cnt_d   = CW'(1);
            end else if (an_idle) begin
                state_d = ST_IDLE;
            end else begin
                state_d  = ST_IDLE;
                an_err_d = 1'b1;
            end
        end
    end

    assign complete   = sampled_q && (seen_q == 4'hF);
    assign frame_same = ({shadow_dp_q, shadow_q} == {cand_dp_q, cand_q});
    assign timed_out  = (to_q == TO_MAX) && !complete;
    assign publish    = pub_q && (!locked_q || ({cand_dp_q, cand_q} != {dp_q, digit_q}));

    always_comb begin
        match_d = match_q;
        if (complete) begin
            if (!frame_same) begin
                match_d = MW'(1);
            end else if (match_q != MATCH_MAX) begin
                match_d = match_q + 1'b1;
            end
        end else if (timed_out) begin
            match_d = '0;
        end
        if (sample_en && !dec_vld) begin
            match_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            an_r_q      <= 4'hF;
            an_p_q      <= 4'hF;
            seg_r_q     <= 7'h7F;
            dp_r_q      <= 1'b1;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            cand_q      <= '0;
            cand_dp_q   <= '0;
            digit_q     <= '0;
            dp_q        <= '0;
            seen_q      <= '0;
            sampled_q   <= 1'b0;
            pub_q       <= 1'b0;
            match_q     <= '0;
            to_q        <= '0;
            fv_q        <= 1'b0;
            locked_q    <= 1'b0;
            dec_err_q   <= 1'b0;
            an_err_q    <= 1'b0;
        end else begin
            an_r_q    <= an_in;
            an_p_q    <= an_r_q;
            seg_r_q   <= seg_in[6:0];
            dp_r_q    <= dp_raw;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sampled_q <= sample_en;
            an_err_q  <= an_err_d;
            dec_err_q <= sample_en && !dec_vld;
            match_q   <= match_d;
            pub_q     <= complete && (match_d == MATCH_MAX);
            fv_q      <= publish;

            if (sample_en) begin
                if (dec_vld) begin
                    shadow_q[{pos, 2'b00} +: 4] <= dec_bcd;
                    shadow_dp_q[pos]            <= ~dp_r_q;
                    seen_q[pos]                 <= 1'b1;
                end else begin
                    seen_q <= '0;
                end
            end

            if (complete) begin
                seen_q <= '0;
                to_q   <= '0;
                if (!frame_same) begin
                    cand_q    <= shadow_q;
                    cand_dp_q <= shadow_dp_q;
                end
            end else if (to_q != TO_MAX) begin
                to_q <= to_q + 1'b1;
            end

            if (timed_out) begin
                locked_q <= 1'b0;
            end
            if (publish) begin
                digit_q  <= cand_q;
                dp_q     <= cand_dp_q;
                locked_q <= 1'b1;
            end
        end
    end

    assign digit_out   = digit_q;
`ifdef SEG_CAPTURE_DP_EN
    assign dp_out      = dp_q;
`else
    assign dp_out      = 4'b0000;
`endif
    assign frame_valid = fv_q;
    assign locked      = locked_q;
    assign decode_err  = dec_err_q;
    assign an_err      = an_err_q;

endmodule
